// File: rtl/cpu_ctrl_fsm_v2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_ctrl_fsm_v2 : multicycle control FSM for the 16-bit CPU          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cpu_ctrl_fsm_v2 #(
  parameter int NSEL_W   = 3,
  parameter int VSEL_W   = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        opcode,
  input  logic [1:0]        op,
  input  logic [2:0]        cond,
  input  logic [2:0]        status,
  input  logic              mem_ready,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic              write,
  output logic [NSEL_W-1:0] nsel,
  output logic [VSEL_W-1:0] vsel,
  output logic              load_ir,
  output logic              load_pc,
  output logic              reset_pc,
  output logic [1:0]        pc_sel,
  output logic              addr_sel,
  output logic              load_addr,
  output logic [1:0]        mem_cmd,
  output logic              halted,
  output logic              mem_err
);

  localparam int                c_cnt_w     = $clog2(WAIT_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(WAIT_MAX - 1);
  localparam logic [NSEL_W-1:0] c_nsel_rn   = NSEL_W'(3'b100);
  localparam logic [NSEL_W-1:0] c_nsel_rd   = NSEL_W'(3'b010);
  localparam logic [NSEL_W-1:0] c_nsel_rm   = NSEL_W'(3'b001);
  localparam logic [VSEL_W-1:0] c_vsel_c    = VSEL_W'(4'b0001);
  localparam logic [VSEL_W-1:0] c_vsel_pc   = VSEL_W'(4'b0010);
  localparam logic [VSEL_W-1:0] c_vsel_imm  = VSEL_W'(4'b0100);
  localparam logic [VSEL_W-1:0] c_vsel_mdat = VSEL_W'(4'b1000);
  localparam logic [1:0]        c_cmd_read  = 2'b01;
  localparam logic [1:0]        c_cmd_write = 2'b10;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC,
    S_GETA, S_GETB, S_EXE, S_WREG,
    S_MOVI, S_MOV1, S_MOV2, S_MOV3,
    S_LA, S_LADD, S_LADR, S_LRD, S_LWB,
    S_SA, S_SADD, S_SADR, S_SC, S_SWR,
    S_BRT, S_BRN, S_BL, S_BXR, S_BXC, S_BXP, S_BLR,
    S_HALT, S_ERR
  } state_t;

  typedef struct packed {
    logic              loada;
    logic              loadb;
    logic              loadc;
    logic              loads;
    logic              asel;
    logic              bsel;
    logic              write;
    logic [NSEL_W-1:0] nsel;
    logic [VSEL_W-1:0] vsel;
    logic              load_pc;
    logic              reset_pc;
    logic [1:0]        pc_sel;
    logic              addr_sel;
    logic              load_addr;
    logic [1:0]        mem_cmd;
    logic              halted;
    logic              mem_err;
  } ctrl_t;

  state_t               state_q, state_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic [c_cnt_w-1:0]   wait_q, wait_d;
  logic                 n_ne_v;
  logic                 taken;

  always_comb begin
    n_ne_v = status[2] ^ status[1];
    case (cond)
      3'b000:  taken = 1'b1;
      3'b001:  taken = status[0];
      3'b010:  taken = ~status[0];
      3'b011:  taken = n_ne_v;
      3'b100:  taken = n_ne_v | status[0];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      S_RST:  state_d = S_IF1;
      S_IF1:  state_d = S_IF2;
      // The wait count only survives while a memory state holds on mem_ready=0.
      S_IF2, S_LRD, S_SWR: begin
        if (mem_ready) begin
          case (state_q)
            S_IF2:   state_d = S_UPC;
            S_LRD:   state_d = S_LWB;
            default: state_d = S_IF1;
          endcase
        end else if (wait_q == c_wait_last) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + c_cnt_w'(1);
        end
      end
      S_UPC:  state_d = S_DEC;
      S_DEC: begin
        casez ({opcode, op})
          5'b11010: state_d = S_MOVI;
          5'b11000: state_d = S_MOV1;
          5'b101??: state_d = S_GETA;
          5'b01100: state_d = S_LA;
          5'b10000: state_d = S_SA;
          5'b001??: state_d = (cond > 3'b100) ? S_ERR : (taken ? S_BRT : S_BRN);
          5'b01011: state_d = S_BL;
          5'b01000: state_d = S_BXR;
          5'b01010: state_d = S_BLR;
          5'b111??: state_d = S_HALT;
          default:  state_d = S_ERR;
        endcase
      end
      S_GETA: state_d = S_GETB;
      S_GETB: state_d = S_EXE;
      S_EXE:  state_d = (op == 2'b01) ? S_IF1 : S_WREG;
      S_MOV1: state_d = S_MOV2;
      S_MOV2: state_d = S_MOV3;
      S_LA:   state_d = S_LADD;
      S_LADD: state_d = S_LADR;
      S_LADR: state_d = S_LRD;
      S_SA:   state_d = S_SADD;
      S_SADD: state_d = S_SADR;
      S_SADR: state_d = S_SC;
      S_SC:   state_d = S_SWR;
      S_BLR:  state_d = S_BXR;
      S_BXR:  state_d = S_BXC;
      S_BXC:  state_d = S_BXP;
      S_HALT: state_d = S_HALT;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IF1;
    endcase
  end

  // Outputs are decoded from the next state so the registered copy lines up with state_q.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_IF1, S_IF2: begin ctrl_d.addr_sel = 1'b1; ctrl_d.mem_cmd = c_cmd_read; end
      S_UPC:        ctrl_d.load_pc = 1'b1;
      S_GETA, S_LA, S_SA: begin ctrl_d.nsel = c_nsel_rn; ctrl_d.loada = 1'b1; end
      S_GETB, S_MOV1: begin ctrl_d.nsel = c_nsel_rm; ctrl_d.loadb = 1'b1; end
      S_EXE:        begin ctrl_d.loadc = 1'b1; ctrl_d.loads = 1'b1; end
      S_WREG, S_MOV3: begin ctrl_d.nsel = c_nsel_rd; ctrl_d.vsel = c_vsel_c; ctrl_d.write = 1'b1; end
      S_MOVI:       begin ctrl_d.nsel = c_nsel_rn; ctrl_d.vsel = c_vsel_imm; ctrl_d.write = 1'b1; end
      S_MOV2, S_SC, S_BXC: begin ctrl_d.asel = 1'b1; ctrl_d.loadc = 1'b1; end
      S_LADD, S_SADD: begin ctrl_d.bsel = 1'b1; ctrl_d.loadc = 1'b1; end
      S_LADR:       ctrl_d.load_addr = 1'b1;
      S_LRD:        ctrl_d.mem_cmd = c_cmd_read;
      S_LWB:        begin ctrl_d.nsel = c_nsel_rd; ctrl_d.vsel = c_vsel_mdat; ctrl_d.write = 1'b1; end
      S_SADR:       begin ctrl_d.load_addr = 1'b1; ctrl_d.nsel = c_nsel_rd; ctrl_d.loadb = 1'b1; end
      S_SWR:        ctrl_d.mem_cmd = c_cmd_write;
      S_BRT:        begin ctrl_d.load_pc = 1'b1; ctrl_d.pc_sel = 2'b01; end
      S_BL: begin
        ctrl_d.nsel    = c_nsel_rn;
        ctrl_d.vsel    = c_vsel_pc;
        ctrl_d.write   = 1'b1;
        ctrl_d.load_pc = 1'b1;
        ctrl_d.pc_sel  = 2'b01;
      end
      S_BXR:        begin ctrl_d.nsel = c_nsel_rd; ctrl_d.loadb = 1'b1; end
      S_BXP:        begin ctrl_d.load_pc = 1'b1; ctrl_d.pc_sel = 2'b10; end
      S_BLR:        begin ctrl_d.nsel = c_nsel_rn; ctrl_d.vsel = c_vsel_pc; ctrl_d.write = 1'b1; end
      S_HALT:       ctrl_d.halted = 1'b1;
      S_ERR:        ctrl_d.mem_err = 1'b1;
      default:      ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_RST;
      wait_q          <= '0;
      ctrl_q          <= '0;
      ctrl_q.reset_pc <= 1'b1;
      ctrl_q.load_pc  <= 1'b1;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign {loada, loadb, loadc, loads, asel, bsel, write, nsel, vsel,
          load_pc, reset_pc, pc_sel, addr_sel, load_addr, mem_cmd, halted, mem_err} = ctrl_q;

  // IR capture must coincide with the cycle memory actually returns the word.
  assign load_ir = (state_q == S_IF2) && mem_ready;

endmodule
`default_nettype wire
